// File: rtl/main.sv
// Vending-machine controller: purchase, restock and stock query over
// 8 product types, with registered seven-segment displays.
module main #(
    parameter logic [6:0] PRICE0     = 7'd5,
    parameter logic [6:0] PRICE1     = 7'd3,
    parameter logic [6:0] PRICE2     = 7'd8,
    parameter logic [6:0] PRICE3     = 7'd10,
    parameter logic [6:0] PRICE4     = 7'd2,
    parameter logic [6:0] PRICE5     = 7'd6,
    parameter logic [6:0] PRICE6     = 7'd4,
    parameter logic [6:0] PRICE7     = 7'd7,
    parameter logic [3:0] INIT_STOCK = 4'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [6:0] customer_money,
    input  logic [2:0] supply_type,
    input  logic [3:0] customer_amount,
    input  logic [3:0] amount_sypply_to_add,
    output logic [6:0] error,
    output logic [6:0] First7_machine,
    output logic [6:0] Second7_machine,
    output logic [6:0] First7_customer,
    output logic [6:0] Second7_customer
);

    logic [7:0][3:0] stock, stock_n;
    logic [13:0]     cash, cash_n;
    logic [6:0]      change, change_n;
    logic [2:0]      err, err_n;
    logic [6:0]      mach_n;
    logic [6:0]      price;
    logic [10:0]     cost;
    logic [4:0]      sum;
    logic [14:0]     cash_sum;
    logic [13:0]     mach_disp, cust_disp;
    logic [6:0]      err_seg;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Two digits {tens, units}; values above 99 pin at 99.
    function automatic logic [13:0] two_digit(input logic [6:0] v);
        logic [6:0] s;
        s = (v > 7'd99) ? 7'd99 : v;
        return {seg(4'(s / 7'd10)), seg(4'(s % 7'd10))};
    endfunction

    always_comb begin
        unique case (supply_type)
            3'd0:    price = PRICE0;
            3'd1:    price = PRICE1;
            3'd2:    price = PRICE2;
            3'd3:    price = PRICE3;
            3'd4:    price = PRICE4;
            3'd5:    price = PRICE5;
            3'd6:    price = PRICE6;
            default: price = PRICE7;
        endcase
    end

    always_comb begin
        stock_n  = stock;
        cash_n   = cash;
        change_n = change;
        err_n    = err;
        cost     = {4'b0, price} * {7'b0, customer_amount};
        sum      = {1'b0, stock[supply_type]} + {1'b0, amount_sypply_to_add};
        cash_sum = {1'b0, cash} + {4'b0, cost};
        unique case (mode)
            2'd1: begin
                change_n = customer_money;
                if (customer_amount == 4'd0) begin
                    err_n = 3'd3;
                end else if (customer_amount > stock[supply_type]) begin
                    err_n = 3'd2;
                end else if ({4'b0, customer_money} < cost) begin
                    err_n = 3'd1;
                end else begin
                    err_n = 3'd0;
                    stock_n[supply_type] = stock[supply_type] - customer_amount;
                    cash_n = (cash_sum > 15'd16383) ? 14'h3FFF : cash_sum[13:0];
                    change_n = 7'({4'b0, customer_money} - cost);
                end
            end
            2'd2: begin
                if (sum > 5'd15) begin
                    err_n = 3'd4;
                end else begin
                    err_n = 3'd0;
                    stock_n[supply_type] = sum[3:0];
                end
            end
            2'd3: err_n = 3'd0;
            default: ;
        endcase
        mach_n = mode[1] ? {3'b0, stock_n[supply_type]}
                         : 7'(cash_n % 14'd100);
        mach_disp = two_digit(mach_n);
        cust_disp = two_digit(change_n);
        err_seg   = (err_n == 3'd0) ? 7'h00 : seg({1'b0, err_n});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stock            <= {8{INIT_STOCK}};
            cash             <= '0;
            change           <= '0;
            err              <= '0;
            error            <= 7'h00;
            First7_machine   <= 7'h3F;
            Second7_machine  <= 7'h3F;
            First7_customer  <= 7'h3F;
            Second7_customer <= 7'h3F;
        end else begin
            stock            <= stock_n;
            cash             <= cash_n;
            change           <= change_n;
            err              <= err_n;
            error            <= err_seg;
            First7_machine   <= mach_disp[13:7];
            Second7_machine  <= mach_disp[6:0];
            First7_customer  <= cust_disp[13:7];
            Second7_customer <= cust_disp[6:0];
        end
    end

endmodule

// File: tb/tb_main.sv
// Scoreboard bench for the vending-machine controller: directed
// vectors push expected display values, a monitor checks after each edge.
module tb_main;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [6:0] customer_money = 7'd0;
    logic [2:0] supply_type = 3'd0;
    logic [3:0] customer_amount = 4'd0;
    logic [3:0] amount_sypply_to_add = 4'd0;
    logic [6:0] error;
    logic [6:0] First7_machine, Second7_machine;
    logic [6:0] First7_customer, Second7_customer;

    typedef struct {
        int    mach;
        int    cust;
        int    err;
        string name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    main dut (
        .clk                 (clk),
        .rst                 (rst),
        .mode                (mode),
        .customer_money      (customer_money),
        .supply_type         (supply_type),
        .customer_amount     (customer_amount),
        .amount_sypply_to_add(amount_sypply_to_add),
        .error               (error),
        .First7_machine      (First7_machine),
        .Second7_machine     (Second7_machine),
        .First7_customer     (First7_customer),
        .Second7_customer    (Second7_customer)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    task automatic step(input logic r, input int m, input int money,
                        input int ty, input int amt, input int add,
                        input int em, input int ec, input int ee,
                        input string name);
        exp_t e;
        @(negedge clk);
        rst                  = r;
        mode                 = 2'(m);
        customer_money       = 7'(money);
        supply_type          = 3'(ty);
        customer_amount      = 4'(amt);
        amount_sypply_to_add = 4'(add);
        e.mach = em;
        e.cust = ec;
        e.err  = ee;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [13:0] act,
                       input logic [13:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [6:0] ee;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                ee = (e.err == 0) ? 7'h00 : seg(e.err);
                cmp({e.name, ".machine"},
                    {First7_machine, Second7_machine},
                    {seg(e.mach / 10), seg(e.mach % 10)});
                cmp({e.name, ".customer"},
                    {First7_customer, Second7_customer},
                    {seg(e.cust / 10), seg(e.cust % 10)});
                cmp({e.name, ".error"}, {7'h00, error}, {7'h00, ee});
            end
        end
    end

    initial begin : driver
        //   rst m  money ty amt add  mach cust err
        step(1, 0,   0, 0, 0,  0,    0,   0, 0, "reset");
        step(0, 3,   0, 0, 0,  0,    5,   0, 0, "query0");
        step(0, 1,  20, 0, 1,  0,    5,  15, 0, "buy0");
        step(0, 1,  10, 3, 1,  0,   15,   0, 0, "buy3");
        step(0, 1,   0, 7, 3,  0,   15,   0, 1, "poor7");
        step(0, 1,  19, 7, 1,  0,   22,  12, 0, "buy7");
        step(0, 0,   0, 0, 0,  0,   22,  12, 0, "idle_hold");
        step(0, 2,   0, 0, 0,  2,    6,  12, 0, "restock0");
        step(0, 3,   0, 0, 0,  0,    6,  12, 0, "query0b");
        step(0, 1,  99, 4, 6,  0,   22,  99, 2, "nostock4");
        step(0, 3,   0, 4, 0,  0,    5,  99, 0, "query4");
        step(0, 1,  30, 2, 0,  0,   22,  30, 3, "amount0");
        step(0, 2,   0, 1, 0, 12,    5,  30, 4, "overflow1");
        step(0, 2,   0, 1, 0, 10,    15, 30, 0, "fill1_15");
        step(0, 2,   0, 1, 0, 1,     15, 30, 4, "over1_16");
        step(0, 1,  60, 1, 10, 0,   52,  30, 0, "buy1x10");
        step(0, 1,  10, 1, 1,  0,   55,   7, 0, "hold1");
        step(0, 1,  10, 1, 1,  0,   58,   7, 0, "hold2");
        step(0, 1,  10, 1, 1,  0,   61,   7, 0, "hold3");
        step(0, 3,   0, 1, 0,  0,    2,   7, 0, "query1");
        step(1, 1,  10, 1, 1,  0,    0,   0, 0, "rst_mid");
        step(0, 3,   0, 1, 0,  0,    5,   0, 0, "query1_rst");
        step(0, 0,   0, 0, 0,  0,    0,   0, 0, "idle_rst");
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d pending, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
